perf_monitor_unit: RTL and testbench
====================================

Name: perf_monitor_unit

Overview:
- Synthesizable, parametrised pipeline performance monitor.
- Counts retired instructions per class, stall events per source, and active cycles.
- Detects the HALT opcode, drains the pipeline for a fixed number of cycles, then freezes all counts.
- Sits beside the core pipeline's writeback stage; results are read back through a registered select/ack port.

Parameters:
- CNT_W, 32, width of every counter and of rd_data.
- NUM_CLASSES, 4, number of instruction classes (arith, logic, mem, ctrl).
- CLASS_W, 2, width of retire_class; must satisfy 2**CLASS_W >= NUM_CLASSES.
- NUM_STALL_SRC, 2, number of independent stall sources (e.g. no-forwarding, with-forwarding).
- HALT_OPCODE, 6'b010001, value of inst[31:26] that marks HALT.
- DRAIN_CYCLES, 6, cycles counted after HALT retires before counts freeze.
- SEL_W, 4, width of rd_sel.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears all counters and begins a run.
- retire_valid  in  1  one instruction retires this cycle.
- retire_class  in  CLASS_W  class index of the retiring instruction.
- retire_inst  in  32  encoding of the retiring instruction.
- stall_vec  in  NUM_STALL_SRC  bit i high = stall source i active this cycle.
- rd_req  in  1  readout request.
- rd_sel  in  SEL_W  counter index to read.
- rd_ack  out  1  rd_data valid.
- rd_data  out  CNT_W  selected counter value.
- running  out  1  high in RUN or DRAIN.
- halted  out  1  high in HALTED.
- ovf  out  1  sticky; set when any counter reaches all-ones.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - All counters = 0.
  - rd_ack = 0, rd_data = 0, running = 0, halted = 0, ovf = 0.
- States: IDLE, RUN, DRAIN, HALTED.
- IDLE:
  - No counting.
  - start -> RUN; all counters and ovf cleared in the same edge.
- RUN:
  - cycle_cnt += 1 every cycle.
  - stall_cnt[i] += 1 for each stall_vec[i] = 1; all sources are counted independently in the same cycle.
  - retire_valid with retire_class < NUM_CLASSES: class_cnt[retire_class] += 1.
  - retire_valid with retire_class >= NUM_CLASSES: discarded.
  - retire_valid with retire_inst[31:26] == HALT_OPCODE: the HALT is counted in its class, drain_cnt loads 0, and the state moves to DRAIN.
  - start in RUN is ignored.
- DRAIN:
  - cycle_cnt and stall counters keep counting.
  - retire_valid is ignored (no class counts).
  - drain_cnt increments each cycle.
  - When drain_cnt == DRAIN_CYCLES-1 -> HALTED; exactly DRAIN_CYCLES cycles are spent in DRAIN.
  - DRAIN_CYCLES = 0 -> go directly from RUN to HALTED.
- HALTED:
  - All counters frozen.
  - start -> clear counters, go to RUN.
- Counters:
  - Default: wrap modulo 2**CNT_W.
  - ovf is set on the edge where any counter transitions to all-ones.
- Readout (latency 1, allowed in every state):
  - A request sampled with rd_req = 1 makes rd_ack = 1 on the next edge, with rd_data = the value at the sampling edge.
  - Back-to-back requests give back-to-back acks.
  - rd_ack = 0 in cycles without a preceding request; rd_data then holds its last value.
- rd_sel map:
  - 0..NUM_CLASSES-1: class counters.
  - next NUM_STALL_SRC indices: stall counters.
  - next index: cycle_cnt.
  - next index: total retired = sum of class counters, truncated to CNT_W.
  - any other index: 0.
- Reset mid-run aborts immediately to IDLE with all counters at 0.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- Defined:
  - Every counter saturates at all-ones and never wraps.
  - ovf is set at saturation.
  - The total-retired sum also saturates at all-ones.
- Undefined: wrap-around behaviour as above; ovf still flags reaching all-ones.

Test Plan:
- Reset then idle: with start never asserted, 20 cycles of retire_valid=1 -> every rd_sel reads 0, running=0, halted=0.
- Class mix: start, then retire 5 class-0, 3 class-1, 4 class-2, 2 class-3 with no stalls, the last being HALT (class 3), then idle:
  - Reads return 5, 3, 4, 2 for classes 0-3; total = 14.
  - halted=1 exactly 7 cycles after the HALT retire edge (1 RUN->DRAIN edge + 6 DRAIN cycles).
  - cycle_cnt = RUN cycles + 6.
- Simultaneous stalls: assert stall_vec=2'b11 for 3 cycles and 2'b01 for 2 cycles during RUN -> stall_cnt[0]=5, stall_cnt[1]=3.
- Drain masking: retire_valid=1 each cycle during DRAIN -> class counts unchanged; with HALTED, a further 10 cycles of stimulus leave every counter unchanged.
- Readout handshake: rd_req held high for 4 cycles with rd_sel=0,1,2,3 -> rd_ack high 4 consecutive cycles with matching data, each one cycle delayed; rd_sel=15 -> 0.
- Overflow / reset:
  - With CNT_W=4, 17 class-0 retires -> without macro reads 1 and ovf=1; with PERF_SATURATE_EN reads 15 and ovf=1.
  - reset low mid-RUN -> all counters read 0 and state is IDLE.

Source files
------------

// File: rtl/perf_monitor_if.sv
//------------------------------------------------------------------------------
// Module      : perf_monitor_if
// Description : Retire/stall observation bus and counter readout port of the
//               performance monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface perf_monitor_if #(
    parameter int CNT_W         = 32,
    parameter int CLASS_W       = 2,
    parameter int NUM_STALL_SRC = 2,
    parameter int SEL_W         = 4
);
    logic                     retire_valid;
    logic [CLASS_W-1:0]       retire_class;
    logic [31:0]              retire_inst;
    logic [NUM_STALL_SRC-1:0] stall_vec;
    logic                     rd_req;
    logic [SEL_W-1:0]         rd_sel;
    logic                     rd_ack;
    logic [CNT_W-1:0]         rd_data;

    modport master (
        output retire_valid, retire_class, retire_inst, stall_vec, rd_req, rd_sel,
        input  rd_ack, rd_data
    );

    modport slave (
        input  retire_valid, retire_class, retire_inst, stall_vec, rd_req, rd_sel,
        output rd_ack, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/perf_monitor_unit.sv
//------------------------------------------------------------------------------
// Module      : perf_monitor_unit
// Description : Pipeline performance monitor: per-class retire, per-source
//               stall and active-cycle counters, HALT drain, registered readout.
//               Define PERF_SATURATE_EN for saturating counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perf_monitor_unit #(
    parameter int         CNT_W         = 32,
    parameter int         NUM_CLASSES   = 4,
    parameter int         CLASS_W       = 2,
    parameter int         NUM_STALL_SRC = 2,
    parameter logic [5:0] HALT_OPCODE   = 6'b010001,
    parameter int         DRAIN_CYCLES  = 6,
    parameter int         SEL_W         = 4
) (
    input  wire            clk,
    input  wire            reset,
    input  wire            start,
    perf_monitor_if.slave  bus,
    output logic           running,
    output logic           halted,
    output logic           ovf
);

    localparam logic [CNT_W-1:0] C_ALL_ONES   = '1;
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam int               C_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST =
        C_DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
`ifdef PERF_SATURATE_EN
    localparam int               C_SUM_W      = CNT_W + $clog2(NUM_CLASSES + 1);
`else
    localparam int               C_SUM_W      = CNT_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_class_cnt [NUM_CLASSES];
    logic [CNT_W-1:0]       r_stall_cnt [NUM_STALL_SRC];
    logic [CNT_W-1:0]       r_cycle_cnt;
    logic [C_DRAIN_W-1:0]   r_drain_cnt;
    logic                   r_ovf;
    logic                   r_rd_ack;
    logic [CNT_W-1:0]       r_rd_data;

    logic [CNT_W-1:0]       w_class_nxt [NUM_CLASSES];
    logic [CNT_W-1:0]       w_stall_nxt [NUM_STALL_SRC];
    logic [CNT_W-1:0]       w_cycle_nxt;
    logic                   w_hit_max;
    logic [C_SUM_W-1:0]     w_sum_wide;
    logic [CNT_W-1:0]       w_total;
    logic [CNT_W-1:0]       w_rd_val;
    logic                   w_is_halt;
    logic                   w_clear;
    logic                   w_count;
    logic                   w_class_hit;
    logic                   w_unused_inst_bits;

    function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
        f_inc = (v == C_ALL_ONES) ? v : v + C_ONE;
`else
        f_inc = v + C_ONE;
`endif
    endfunction

    assign w_is_halt   = bus.retire_valid && (bus.retire_inst[31:26] == HALT_OPCODE);
    assign w_clear     = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
    assign w_count     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_class_hit = bus.retire_valid && (r_state == ST_RUN) &&
                         (int'(bus.retire_class) < NUM_CLASSES);
    assign w_unused_inst_bits = ^bus.retire_inst[25:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_RUN;
            ST_RUN:    if (w_is_halt) w_next_state = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
            ST_DRAIN:  if (r_drain_cnt == C_DRAIN_LAST) w_next_state = ST_HALTED;
            ST_HALTED: if (start) w_next_state = ST_RUN;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Next counter values; w_hit_max flags any counter landing on all-ones.
    always_comb begin
        w_cycle_nxt = r_cycle_cnt;
        w_hit_max   = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) w_class_nxt[i] = r_class_cnt[i];
        for (int i = 0; i < NUM_STALL_SRC; i++) w_stall_nxt[i] = r_stall_cnt[i];
        if (w_count) begin
            w_cycle_nxt = f_inc(r_cycle_cnt);
            w_hit_max   = w_hit_max | (w_cycle_nxt == C_ALL_ONES);
            for (int i = 0; i < NUM_STALL_SRC; i++) begin
                if (bus.stall_vec[i]) begin
                    w_stall_nxt[i] = f_inc(r_stall_cnt[i]);
                    w_hit_max      = w_hit_max | (w_stall_nxt[i] == C_ALL_ONES);
                end
            end
        end
        if (w_class_hit) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (int'(bus.retire_class) == i) begin
                    w_class_nxt[i] = f_inc(r_class_cnt[i]);
                    w_hit_max      = w_hit_max | (w_class_nxt[i] == C_ALL_ONES);
                end
            end
        end
    end

    always_comb begin
        w_sum_wide = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            w_sum_wide = w_sum_wide + C_SUM_W'(r_class_cnt[i]);
        end
`ifdef PERF_SATURATE_EN
        w_total = (w_sum_wide > C_SUM_W'(C_ALL_ONES)) ? C_ALL_ONES : w_sum_wide[CNT_W-1:0];
`else
        w_total = w_sum_wide;
`endif
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (int'(bus.rd_sel) == i) w_rd_val = r_class_cnt[i];
        end
        for (int i = 0; i < NUM_STALL_SRC; i++) begin
            if (int'(bus.rd_sel) == NUM_CLASSES + i) w_rd_val = r_stall_cnt[i];
        end
        if (int'(bus.rd_sel) == NUM_CLASSES + NUM_STALL_SRC)     w_rd_val = r_cycle_cnt;
        if (int'(bus.rd_sel) == NUM_CLASSES + NUM_STALL_SRC + 1) w_rd_val = w_total;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cycle_cnt <= '0;
            r_drain_cnt <= '0;
            r_ovf       <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) r_class_cnt[i] <= '0;
            for (int i = 0; i < NUM_STALL_SRC; i++) r_stall_cnt[i] <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_clear) begin
                r_cycle_cnt <= '0;
                r_drain_cnt <= '0;
                r_ovf       <= 1'b0;
                for (int i = 0; i < NUM_CLASSES; i++) r_class_cnt[i] <= '0;
                for (int i = 0; i < NUM_STALL_SRC; i++) r_stall_cnt[i] <= '0;
            end else begin
                r_cycle_cnt <= w_cycle_nxt;
                for (int i = 0; i < NUM_CLASSES; i++) r_class_cnt[i] <= w_class_nxt[i];
                for (int i = 0; i < NUM_STALL_SRC; i++) r_stall_cnt[i] <= w_stall_nxt[i];
                if (w_hit_max) r_ovf <= 1'b1;
                if ((r_state == ST_RUN) && w_is_halt) begin
                    r_drain_cnt <= '0;
                end else if (r_state == ST_DRAIN) begin
                    r_drain_cnt <= r_drain_cnt + C_DRAIN_W'(1);
                end
            end
        end
    end

    // Readout: data captured only on a request, so it holds between acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= bus.rd_req;
            if (bus.rd_req) r_rd_data <= w_rd_val;
        end
    end

    assign bus.rd_ack  = r_rd_ack;
    assign bus.rd_data = r_rd_data;
    assign running     = w_count;
    assign halted      = (r_state == ST_HALTED);
    assign ovf         = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_perf_monitor_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_perf_monitor_unit
// Description : Scoreboard bench for perf_monitor_unit (32-bit and 4-bit builds).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_perf_monitor_unit;

    localparam logic [31:0] c_halt_inst = {6'b010001, 26'h0};
    localparam logic [31:0] c_near_inst = {6'b010000, 26'h0};
`ifdef PERF_SATURATE_EN
    localparam logic [31:0] c_small_exp = 32'd15;
`else
    localparam logic [31:0] c_small_exp = 32'd1;
`endif

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        retire_valid;
    logic [1:0]  retire_class;
    logic [31:0] retire_inst;
    logic [1:0]  stall_vec;
    logic        rd_req_m;
    logic        rd_req_s;
    logic [3:0]  rd_sel;
    logic        running_m, halted_m, ovf_m;
    logic        running_s, halted_s, ovf_s;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q_m[$];
    exp_t q_s[$];
    exp_t e_m;
    exp_t e_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perf_monitor_if #(.CNT_W(32), .CLASS_W(2), .NUM_STALL_SRC(2), .SEL_W(4)) if_m ();
    perf_monitor_if #(.CNT_W(4),  .CLASS_W(2), .NUM_STALL_SRC(2), .SEL_W(4)) if_s ();

    assign if_m.retire_valid = retire_valid;
    assign if_m.retire_class = retire_class;
    assign if_m.retire_inst  = retire_inst;
    assign if_m.stall_vec    = stall_vec;
    assign if_m.rd_req       = rd_req_m;
    assign if_m.rd_sel       = rd_sel;
    assign if_s.retire_valid = retire_valid;
    assign if_s.retire_class = retire_class;
    assign if_s.retire_inst  = retire_inst;
    assign if_s.stall_vec    = stall_vec;
    assign if_s.rd_req       = rd_req_s;
    assign if_s.rd_sel       = rd_sel;

    perf_monitor_unit #(.CNT_W(32)) u_dut_m (
        .clk(clk), .reset(reset), .start(start), .bus(if_m),
        .running(running_m), .halted(halted_m), .ovf(ovf_m)
    );

    perf_monitor_unit #(.CNT_W(4)) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .bus(if_s),
        .running(running_s), .halted(halted_s), .ovf(ovf_s)
    );

    // Monitors: every ack must match the oldest outstanding request, one cycle later.
    always @(negedge clk) begin
        if (reset && if_m.rd_ack) begin
            checks++;
            if (q_m.size() == 0) begin
                failures++;
                $display("FAIL rd_main unexpected ack data=%0d cycle=%0d", if_m.rd_data, cyc);
            end else begin
                e_m = q_m.pop_front();
                if (if_m.rd_data !== e_m.data || cyc != e_m.cyc) begin
                    failures++;
                    $display("FAIL rd_main got data=%0d at cycle %0d, expected data=%0d at cycle %0d",
                             if_m.rd_data, cyc, e_m.data, e_m.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && if_s.rd_ack) begin
            checks++;
            if (q_s.size() == 0) begin
                failures++;
                $display("FAIL rd_small unexpected ack data=%0d cycle=%0d", if_s.rd_data, cyc);
            end else begin
                e_s = q_s.pop_front();
                if (32'(if_s.rd_data) !== e_s.data || cyc != e_s.cyc) begin
                    failures++;
                    $display("FAIL rd_small got data=%0d at cycle %0d, expected data=%0d at cycle %0d",
                             if_s.rd_data, cyc, e_s.data, e_s.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic issue_m(input logic [3:0] sel, input logic [31:0] exp);
        rd_req_m = 1'b1;
        rd_sel   = sel;
        q_m.push_back('{data: exp, cyc: cyc + 1});
        @(negedge clk);
    endtask

    task automatic issue_s(input logic [3:0] sel, input logic [31:0] exp);
        rd_req_s = 1'b1;
        rd_sel   = sel;
        q_s.push_back('{data: exp, cyc: cyc + 1});
        @(negedge clk);
    endtask

    task automatic retire(input logic v, input logic [1:0] cls, input logic [31:0] inst,
                          input logic [1:0] stl);
        retire_valid = v;
        retire_class = cls;
        retire_inst  = inst;
        stall_vec    = stl;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cls;
        logic [1:0] stl;
        logic [31:0] mix_exp [10];
        logic [3:0]  mix_sel [10];

        reset = 1'b0; start = 1'b0; retire_valid = 1'b0; retire_class = '0;
        retire_inst = '0; stall_vec = '0; rd_req_m = 1'b0; rd_req_s = 1'b0; rd_sel = '0;
        repeat (3) @(negedge clk);
        chk("reset_running", 32'(running_m), 0);
        chk("reset_halted",  32'(halted_m), 0);
        chk("reset_ovf",     32'(ovf_m), 0);
        chk("reset_rd_ack",  32'(if_m.rd_ack), 0);
        chk("reset_rd_data", if_m.rd_data, 0);
        reset = 1'b1;

        // Idle: retires without start must not count.
        for (int i = 0; i < 20; i++) retire(1'b1, 2'(i), 32'h0, 2'b11);
        retire_valid = 1'b0; stall_vec = '0;
        for (int s = 0; s < 10; s++) issue_m(4'(s), 0);
        rd_req_m = 1'b0;
        chk("idle_running", 32'(running_m), 0);
        chk("idle_halted",  32'(halted_m), 0);

        // Class mix with stalls, ending in HALT (class 3).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_running", 32'(running_m), 1);
        for (int k = 0; k < 14; k++) begin
            cls = (k < 5) ? 2'd0 : (k < 8) ? 2'd1 : (k < 12) ? 2'd2 : 2'd3;
            stl = (k < 3) ? 2'b11 : (k < 5) ? 2'b01 : 2'b00;
            retire(1'b1, cls, (k == 13) ? c_halt_inst : c_near_inst, stl);
        end
        // Drain: halted rises on the 7th edge counting the HALT retire edge.
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("drain_halted_%0d", k), 32'(halted_m), (k == 7) ? 1 : 0);
            chk($sformatf("drain_running_%0d", k), 32'(running_m), (k == 7) ? 0 : 1);
            retire(1'b1, 2'(k), 32'h0, 2'b00);
        end
        for (int k = 0; k < 10; k++) retire(1'b1, 2'd0, c_halt_inst, 2'b11);
        retire_valid = 1'b0; stall_vec = '0;

        mix_sel = '{4'd8, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        mix_exp = '{32'd0, 32'd0, 32'd5, 32'd3, 32'd4, 32'd2, 32'd5, 32'd3, 32'd20, 32'd14};
        for (int i = 0; i < 10; i++) issue_m(mix_sel[i], mix_exp[i]);
        rd_req_m = 1'b0;
        @(negedge clk);
        chk("ack_drops", 32'(if_m.rd_ack), 0);
        chk("data_holds", if_m.rd_data, 14);
        chk("halted_stays", 32'(halted_m), 1);
        chk("mix_ovf", 32'(ovf_m), 0);

        // Restart from HALTED; start mid-run is ignored; 4-bit build overflows.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            start = (k == 5);
            retire(1'b1, 2'd0, 32'h0, 2'b00);
        end
        start = 1'b0; retire_valid = 1'b0;
        issue_m(4'd0, 17);
        issue_m(4'd7, 17);
        rd_req_m = 1'b0;
        issue_s(4'd0, c_small_exp);
        rd_req_s = 1'b0;
        @(negedge clk);
        chk("small_ovf", 32'(ovf_s), 1);
        chk("main_ovf",  32'(ovf_m), 0);
        chk("ovf_running", 32'(running_m), 1);

        // Asynchronous reset in the middle of a run.
        retire_valid = 1'b1; stall_vec = 2'b11;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_running", 32'(running_m), 0);
        chk("async_rst_running_s", 32'(running_s), 0);
        chk("async_rst_halted_s", 32'(halted_s), 0);
        @(negedge clk);
        reset = 1'b1; retire_valid = 1'b0; stall_vec = '0;
        issue_m(4'd0, 0);
        issue_m(4'd4, 0);
        issue_m(4'd6, 0);
        issue_m(4'd7, 0);
        rd_req_m = 1'b0;
        issue_s(4'd0, 0);
        rd_req_s = 1'b0;
        chk("rst_running", 32'(running_m), 0);
        chk("rst_halted",  32'(halted_m), 0);
        chk("rst_ovf_s",   32'(ovf_s), 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q_m.size() != 0 || q_s.size() != 0) begin
            failures++;
            $display("FAIL rd_timeout outstanding main=%0d small=%0d expected 0",
                     q_m.size(), q_s.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
